// File: rtl/i2c_types_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_types_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  // SDA level a receiver drives in the ninth clock slot
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_FETCH,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } i2c_target_state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a glitch filter for one I2C line.
// A level change is accepted only after FILTER_LEN consecutive differing
// samples; rise_o/fall_o pulse in the cycle the filtered level changes.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous bus level into the clock domain (idle bus is high)
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples disagreeing with the filtered level
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: decodes START/STOP/address/data on filtered bus levels,
// streams write bytes out and read bytes in, optionally stretching SCL
// while read data is not yet available.
module i2c_target_responder
  import i2c_types_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h22,
  parameter int                    FILTER_LEN  = 3,
  parameter bit                    STRETCH_EN  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_o,
  output logic                  sda_o,
  output logic [I2C_DATA_W-1:0] wr_data_o,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic                  rd_req_o,
  input  logic [I2C_DATA_W-1:0] rd_data_i,
  input  logic                  rd_valid_i,
  output logic                  start_o,
  output logic                  stop_o,
  output logic                  busy_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .line_i  (scl_i),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .line_i  (sda_i),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  // SDA edges while SCL is high are bus conditions, never data
  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_target_state_t     state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [I2C_DATA_W-1:0] shift_q, shift_d;
  logic [I2C_DATA_W-1:0] wr_data_q, wr_data_d;
  logic [I2C_DATA_W-1:0] rx_byte;
  logic                  accept_q, accept_d;
  logic                  scl_q, scl_d;
  logic                  sda_q, sda_d;
  logic                  wr_valid_q, wr_valid_d;
  logic                  rd_req_q, rd_req_d;
  logic                  start_q, start_d;
  logic                  stop_q, stop_d;
  logic                  busy_q, busy_d;

  // Byte as it stands once the bit on the current SCL rise is shifted in
  assign rx_byte = {shift_q[I2C_DATA_W-2:0], sda_lvl};

  // Next-state and output decode; bus conditions override every state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    wr_data_d  = wr_data_q;
    accept_d   = accept_q;
    scl_d      = scl_q;
    sda_d      = sda_q;
    wr_valid_d = 1'b0;
    rd_req_d   = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    busy_d     = busy_q;

    if (start_det) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      shift_d = '0;
      scl_d   = 1'b1;
      sda_d   = 1'b1;
      start_d = 1'b1;
      busy_d  = 1'b1;
    end else if (stop_det) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      scl_d   = 1'b1;
      sda_d   = 1'b1;
      stop_d  = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          scl_d = 1'b1;
          sda_d = 1'b1;
        end

        ADDR: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            // Not addressed: keep SDA released and sit out the transfer
            if (cnt_q == 4'd7 && rx_byte[7:1] != TARGET_ADDR) begin
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_d   = I2C_ACK;
            state_d = ADDR_ACK;
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            sda_d = 1'b1;
            cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d  = RD_FETCH;
              rd_req_d = 1'b1;
              scl_d    = ~STRETCH_EN;
            end else begin
              state_d = WR_BYTE;
            end
          end
        end

        WR_BYTE: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              wr_data_d  = rx_byte;
              accept_d   = wr_ready_i;
              wr_valid_d = wr_ready_i;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (accept_q) begin
              sda_d   = I2C_ACK;
              state_d = WR_ACK;
            end else begin
              sda_d   = I2C_NACK;
              state_d = WAIT_STOP;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            sda_d   = 1'b1;
            cnt_d   = 4'd0;
            state_d = WR_BYTE;
          end
        end

        RD_FETCH: begin
          // The request pulse cycle itself is skipped; data is taken after it
          if (!rd_req_q) begin
            if (rd_valid_i || !STRETCH_EN) begin
              // Keep the byte pre-shifted so bit 7 is always the next bit out
              shift_d = rd_valid_i ? {rd_data_i[I2C_DATA_W-2:0], 1'b0}
                                   : {{(I2C_DATA_W-1){1'b1}}, 1'b0};
              sda_d   = rd_valid_i ? rd_data_i[I2C_DATA_W-1] : 1'b1;
              scl_d   = 1'b1;
              cnt_d   = 4'd0;
              state_d = RD_BYTE;
            end
          end
        end

        RD_BYTE: begin
          if (scl_rise && cnt_q < 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_d   = 1'b1;
              cnt_d   = 4'd0;
              state_d = RD_ACK;
            end else begin
              sda_d   = shift_q[I2C_DATA_W-1];
              shift_d = {shift_q[I2C_DATA_W-2:0], 1'b0};
            end
          end
        end

        RD_ACK: begin
          if (scl_rise && sda_lvl == I2C_NACK) begin
            state_d = WAIT_STOP;
          end else if (scl_fall) begin
            state_d  = RD_FETCH;
            rd_req_d = 1'b1;
            scl_d    = ~STRETCH_EN;
            cnt_d    = 4'd0;
          end
        end

        WAIT_STOP: begin
          scl_d = 1'b1;
          sda_d = 1'b1;
        end

        default: begin
          state_d = IDLE;
          scl_d   = 1'b1;
          sda_d   = 1'b1;
        end
      endcase
    end
  end

  // State and registered outputs; reset releases both bus lines at once
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= '0;
      wr_data_q  <= '0;
      accept_q   <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      wr_data_q  <= wr_data_d;
      accept_q   <= accept_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      wr_valid_q <= wr_valid_d;
      rd_req_q   <= rd_req_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
    end
  end

  assign scl_o      = scl_q;
  assign sda_o      = sda_q;
  assign wr_data_o  = wr_data_q;
  assign wr_valid_o = wr_valid_q;
  assign rd_req_o   = rd_req_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign busy_o     = busy_q;

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
Synthesizable I2C target (slave) that answers the I2CMB master on one bus segment. It is the responder end of the protocol driven by the I2CMB DUT. It oversamples SCL/SDA on the system clock, decodes START/STOP/address/data, and ACKs/NACKs. Write bytes stream out and read bytes stream in over valid/ready handshakes, with optional clock stretching. It replaces the behavioural i2c_pkg target in gate-level and emulation runs.

Parameters:
TARGET_ADDR, 7'h22, 7-bit address this target responds to
FILTER_LEN, 3, consecutive equal samples required to accept an SCL/SDA level change (glitch filter)
STRETCH_EN, 1, 1 = hold SCL low while read data is unavailable; 0 = send 8'hFF instead

Ports:
clk_i  in  1  system clock, ≥ 16x SCL frequency
rst_i  in  1  reset, asynchronous, active-low
scl_i  in  1  bus SCL level (async)
sda_i  in  1  bus SDA level (async)
scl_o  out  1  0 = pull SCL low, 1 = release (open-drain)
sda_o  out  1  0 = pull SDA low, 1 = release
wr_data_o  out  8  received write byte
wr_valid_o  out  1  one-cycle pulse, wr_data_o valid
wr_ready_i  in  1  sink can accept; sampled at 8th bit to choose ACK/NACK
rd_req_o  out  1  one-cycle pulse requesting next read byte
rd_data_i  in  8  read byte
rd_valid_i  in  1  rd_data_i valid; consumed on first high cycle after rd_req_o
start_o  out  1  one-cycle pulse on START or repeated START
stop_o  out  1  one-cycle pulse on STOP
busy_o  out  1  high from START until STOP

Behaviour:
- Reset (rst_i low, async): scl_o=1, sda_o=1, all pulses 0, busy_o=0, FSM=IDLE, shift register=0. Reset mid-transfer releases both lines immediately.
- Inputs pass through a 2-FF synchronizer, then the FILTER_LEN filter. Edges are detected on filtered levels.
- Events: START = SDA fall while SCL high. STOP = SDA rise while SCL high. Either event overrides every state, cancels any stretch, releases sda_o, and pulses start_o or stop_o one cycle after detection.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_FETCH, RD_BYTE, RD_ACK, WAIT_STOP.
  - START from any state -> ADDR, bit counter = 0.
  - Bits are sampled on SCL rise, MSB first. SDA is changed only on filtered SCL fall, never while SCL is high.
  - ADDR: after 8 bits, compare [7:1] with TARGET_ADDR.
    - Mismatch: release SDA -> WAIT_STOP.
    - Match: drive ACK (sda_o=0) for the 9th clock.
    - ADDR_ACK then goes to WR_BYTE if R/W=0, or RD_FETCH if R/W=1.
  - WR_BYTE: at the 8th rise, load wr_data_o.
    - wr_ready_i=1: pulse wr_valid_o and ACK.
    - wr_ready_i=0: NACK, no pulse -> WAIT_STOP after the 9th clock.
    - After ACK -> WR_BYTE.
  - RD_FETCH: entered on SCL fall ending the ACK slot. Pulse rd_req_o.
    - STRETCH_EN=1: hold scl_o=0 until rd_valid_i, latch the byte, release SCL. Stretch length is unbounded.
    - STRETCH_EN=0: if rd_valid_i is not seen within 1 cycle, load 8'hFF.
    - Then drive MSB -> RD_BYTE.
  - RD_BYTE: shift the next bit out on each SCL fall. After the 8th fall release SDA -> RD_ACK.
  - RD_ACK: sample SDA on the 9th rise. 0 (ACK) -> RD_FETCH; 1 (NACK) -> WAIT_STOP.
  - WAIT_STOP: lines released; wait for STOP or START.
- START and STOP in the same filtered cycle are impossible; a STOP detected while stretching releases SCL the next cycle.
- Bit counter is 4 bits and wraps 0..8 per byte.
- wr_valid_o and rd_req_o never assert in the same cycle.

Decomposition:
- Shared package i2c_types_pkg gets:
  - enum i2c_target_state_t (the 9 states)
  - I2C_ADDR_W=7, I2C_DATA_W=8
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1
- Sub-module i2c_line_filter, instantiated twice (SCL, SDA): 2-FF synchronizer plus FILTER_LEN saturating counter. Outputs a filtered level plus rise and fall pulses.

Test Plan:
- Write 0x44 (addr 0x22,W), data 0x5A, 0xA5, wr_ready_i=1 -> ACK on all 3 bytes; wr_valid_o pulses twice with 0x5A then 0xA5; start_o=1 pulse, stop_o=1 pulse.
- Address 0x46 (0x23,W) -> SDA released at 9th clock (NACK); no wr_valid_o; busy_o falls after STOP.
- Read 0x45, rd_data_i=0xC3 valid immediately, master ACK then NACK -> SDA bits 1100_0011 then second byte; rd_req_o pulses exactly 2 times.
- STRETCH_EN=1, rd_valid_i delayed 50 clks -> scl_o=0 for ≥ 48 clks; the byte is transferred intact after release.
- Write 0x5A, then repeated START with 0x45 read -> start_o pulses twice; FSM goes to RD_FETCH without STOP.
- rst_i asserted mid-RD_BYTE while driving 0 -> sda_o=1 and scl_o=1 within the same cycle; the next START is decoded normally.
